// File: rtl/stream_aux_checker_if.sv
// AXI-Stream style handshake bundle between the counting source and the checker sink.
interface stream_aux_checker_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/stream_aux_checker.sv
// Stream test sink: applies a tready backpressure mask and checks one packet of
// incrementing words (1, 2, ...) with tlast on the word equal to total_num.
module stream_aux_checker #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_aux_checker_if.slave   axis,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] total_num,
  input  logic [7:0]            ready_pattern,
  output logic                  done,
  output logic                  pass,
  output logic                  data_err,
  output logic                  last_err,
  output logic                  timeout,
  output logic [DATA_WIDTH-1:0] beat_count,
  output logic [DATA_WIDTH-1:0] mismatch_count
);

  localparam int unsigned TcW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TcW-1:0] ToLast = TcW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] One = DATA_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e                state_q, state_d;
  logic                  tready_q, tready_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  data_err_q, data_err_d;
  logic                  last_err_q, last_err_d;
  logic                  timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [DATA_WIDTH-1:0] mismatch_q, mismatch_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [DATA_WIDTH-1:0] total_q, total_d;
  logic [2:0]            phase_q, phase_d;
  logic [TcW-1:0]        to_cnt_q, to_cnt_d;
  logic                  hs;

  always_comb begin
    state_d      = state_q;
    tready_d     = tready_q;
    done_d       = done_q;
    pass_d       = pass_q;
    data_err_d   = data_err_q;
    last_err_d   = last_err_q;
    timeout_d    = timeout_q;
    beat_count_d = beat_count_q;
    mismatch_d   = mismatch_q;
    expected_d   = expected_q;
    total_d      = total_q;
    phase_d      = phase_q;
    to_cnt_d     = to_cnt_q;
    hs           = axis.tvalid && tready_q && (state_q == StRecv);

    unique case (state_q)
      StIdle: begin
        tready_d = 1'b0;
        if (enable) begin
          state_d      = StRecv;
          total_d      = total_num;
          expected_d   = One;
          beat_count_d = '0;
          mismatch_d   = '0;
          data_err_d   = 1'b0;
          last_err_d   = 1'b0;
          timeout_d    = 1'b0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          to_cnt_d     = '0;
          phase_d      = 3'd0;
          // First RECV cycle already honours the mask at phase 0.
          tready_d     = ready_pattern[0];
        end
      end
      StRecv: begin
        phase_d  = phase_q + 3'd1;
        tready_d = ready_pattern[phase_d];
        if (hs) begin
          to_cnt_d     = '0;
          beat_count_d = beat_count_q + One;
          expected_d   = expected_q + One;
          if (axis.tdata != expected_q) begin
            data_err_d = 1'b1;
            if (mismatch_q != '1) mismatch_d = mismatch_q + One;
          end
          if (axis.tlast) begin
            if (expected_q != total_q) last_err_d = 1'b1;
            state_d = StDone;
          end else if (expected_q == total_q) begin
            // Overrun: flag it but keep checking until the source ends the packet.
            last_err_d = 1'b1;
          end
        end else if (to_cnt_q == ToLast) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          to_cnt_d = to_cnt_q + TcW'(1);
        end
        if (state_d == StDone) begin
          tready_d = 1'b0;
          done_d   = 1'b1;
          pass_d   = !(data_err_d || last_err_d || timeout_d);
        end
      end
      StDone: begin
        tready_d = 1'b0;
      end
      default: begin
        state_d  = StIdle;
        tready_d = 1'b0;
      end
    endcase

    // Dropping enable aborts to IDLE; results hold until the next run starts.
    if (!enable) begin
      state_d  = StIdle;
      tready_d = 1'b0;
      done_d   = done_q;
      pass_d   = pass_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tready_q     <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      data_err_q   <= 1'b0;
      last_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
      beat_count_q <= '0;
      mismatch_q   <= '0;
      expected_q   <= One;
      total_q      <= '0;
      phase_q      <= 3'd0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      tready_q     <= tready_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      data_err_q   <= data_err_d;
      last_err_q   <= last_err_d;
      timeout_q    <= timeout_d;
      beat_count_q <= beat_count_d;
      mismatch_q   <= mismatch_d;
      expected_q   <= expected_d;
      total_q      <= total_d;
      phase_q      <= phase_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign axis.tready    = tready_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign data_err       = data_err_q;
  assign last_err       = last_err_q;
  assign timeout        = timeout_q;
  assign beat_count     = beat_count_q;
  assign mismatch_count = mismatch_q;

endmodule

// File: tb/tb_stream_aux_checker.sv
// Directed bench for stream_aux_checker acting as the upstream counting source.
module tb_stream_aux_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] total_num;
  logic [7:0]  ready_pattern;
  logic        done, pass, data_err, last_err, timeout;
  logic [31:0] beat_count, mismatch_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   rc       = 0;
  int   cyc_acc  = 0;
  bit   pat_chk  = 0;
  logic [7:0] pat;

  stream_aux_checker_if #(.DATA_WIDTH(32)) sif ();

  stream_aux_checker #(
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .axis           (sif),
    .enable         (enable),
    .total_num      (total_num),
    .ready_pattern  (ready_pattern),
    .done           (done),
    .pass           (pass),
    .data_err       (data_err),
    .last_err       (last_err),
    .timeout        (timeout),
    .beat_count     (beat_count),
    .mismatch_count (mismatch_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Leave any previous run via IDLE, program the run, and land in RECV cycle 0.
  task automatic start_run(input logic [31:0] total, input logic [7:0] p);
    enable = 1'b0;
    sif.tvalid = 1'b0;
    sif.tlast  = 1'b0;
    cyc();
    total_num     = total;
    ready_pattern = p;
    pat           = p;
    enable        = 1'b1;
    cyc();
    rc      = 0;
    cyc_acc = 0;
  endtask

  // Hold one beat until it is accepted (bounded), tracking RECV cycles used.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    bit hs;
    n  = 0;
    hs = 1'b0;
    sif.tdata  = d;
    sif.tvalid = 1'b1;
    sif.tlast  = last;
    while (!hs && n < 64) begin
      #3;
      if (pat_chk) check("tready_pattern", 32'(sif.tready), 32'(pat[rc % 8]));
      hs = sif.tready && sif.tvalid;
      cyc();
      n++;
      rc++;
    end
    check("beat_accepted", 32'(hs), 32'd1);
    sif.tvalid = 1'b0;
    sif.tlast  = 1'b0;
    cyc_acc += n;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    total_num = '0;
    ready_pattern = 8'hFF;
    pat = 8'hFF;
    sif.tdata  = '0;
    sif.tvalid = 1'b0;
    sif.tlast  = 1'b0;
    #12;
    check("rst_tready", 32'(sif.tready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_errs", 32'({data_err, last_err, timeout}), 32'd0);
    check("rst_beat_count", beat_count, 32'd0);
    check("rst_mismatch", mismatch_count, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Clean 4-beat packet, no backpressure.
    start_run(32'd4, 8'hFF);
    check("t1_tready_first", 32'(sif.tready), 32'd1);
    send_beat(32'd1, 1'b0);
    check("t1_beat_count_lat", beat_count, 32'd1);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    check("t1_done_early", 32'(done), 32'd0);
    send_beat(32'd4, 1'b1);
    check("t1_cycles", 32'(cyc_acc), 32'd4);
    check("t1_done", 32'(done), 32'd1);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_beat_count", beat_count, 32'd4);
    check("t1_mismatch", mismatch_count, 32'd0);
    check("t1_tready_done", 32'(sif.tready), 32'd0);

    // 16 beats under mask 1010_0101.
    start_run(32'd16, 8'b1010_0101);
    pat_chk = 1'b1;
    for (int i = 1; i <= 16; i++) send_beat(32'(i), i == 16);
    pat_chk = 1'b0;
    check("t2_cycles", 32'(cyc_acc), 32'd32);
    check("t2_done", 32'(done), 32'd1);
    check("t2_pass", 32'(pass), 32'd1);
    check("t2_beat_count", beat_count, 32'd16);

    // Corrupted beat 3.
    start_run(32'd5, 8'hFF);
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    check("t3_no_err_yet", 32'(data_err), 32'd0);
    send_beat(32'd33, 1'b0);
    check("t3_data_err_lat", 32'(data_err), 32'd1);
    check("t3_mismatch_lat", mismatch_count, 32'd1);
    send_beat(32'd4, 1'b0);
    send_beat(32'd5, 1'b1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_pass", 32'(pass), 32'd0);
    check("t3_mismatch", mismatch_count, 32'd1);
    check("t3_last_err", 32'(last_err), 32'd0);
    check("t3_beat_count", beat_count, 32'd5);

    // Early tlast on beat 3 of 5.
    start_run(32'd5, 8'hFF);
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b1);
    check("t4a_done", 32'(done), 32'd1);
    check("t4a_last_err", 32'(last_err), 32'd1);
    check("t4a_data_err", 32'(data_err), 32'd0);
    check("t4a_beat_count", beat_count, 32'd3);
    check("t4a_pass", 32'(pass), 32'd0);

    // Missing tlast on beat 5, sent on beat 6.
    start_run(32'd5, 8'hFF);
    for (int i = 1; i <= 4; i++) send_beat(32'(i), 1'b0);
    check("t4b_no_last_err", 32'(last_err), 32'd0);
    send_beat(32'd5, 1'b0);
    check("t4b_last_err_lat", 32'(last_err), 32'd1);
    check("t4b_not_done", 32'(done), 32'd0);
    send_beat(32'd6, 1'b1);
    check("t4b_done", 32'(done), 32'd1);
    check("t4b_beat_count", beat_count, 32'd6);
    check("t4b_data_err", 32'(data_err), 32'd0);
    check("t4b_pass", 32'(pass), 32'd0);

    // Timeout with tvalid idle.
    start_run(32'd4, 8'hFF);
    for (int i = 0; i < 15; i++) cyc();
    check("t5a_timeout_pre", 32'(timeout), 32'd0);
    check("t5a_done_pre", 32'(done), 32'd0);
    cyc();
    check("t5a_timeout", 32'(timeout), 32'd1);
    check("t5a_done", 32'(done), 32'd1);
    check("t5a_pass", 32'(pass), 32'd0);
    check("t5a_beat_count", beat_count, 32'd0);

    // Timeout with a zero mask while the source is valid.
    start_run(32'd4, 8'h00);
    sif.tdata  = 32'd1;
    sif.tvalid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check("t5b_tready_low", 32'(sif.tready), 32'd0);
      cyc();
    end
    check("t5b_timeout_pre", 32'(timeout), 32'd0);
    cyc();
    check("t5b_timeout", 32'(timeout), 32'd1);
    check("t5b_done", 32'(done), 32'd1);
    check("t5b_pass", 32'(pass), 32'd0);
    check("t5b_beat_count", beat_count, 32'd0);
    sif.tvalid = 1'b0;

    // Asynchronous reset mid-packet, then a fresh clean run.
    start_run(32'd8, 8'hFF);
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("t6_rst_beat_count", beat_count, 32'd0);
    check("t6_rst_tready", 32'(sif.tready), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    start_run(32'd8, 8'hFF);
    for (int i = 1; i <= 8; i++) send_beat(32'(i), i == 8);
    check("t6_done", 32'(done), 32'd1);
    check("t6_pass", 32'(pass), 32'd1);
    check("t6_beat_count", beat_count, 32'd8);

    // Enable dropped mid-run: IDLE with results held.
    start_run(32'd8, 8'hFF);
    send_beat(32'd1, 1'b0);
    send_beat(32'd9, 1'b0);
    send_beat(32'd3, 1'b0);
    enable = 1'b0;
    cyc();
    check("t7_tready", 32'(sif.tready), 32'd0);
    check("t7_data_err", 32'(data_err), 32'd1);
    check("t7_beat_count", beat_count, 32'd3);
    check("t7_mismatch", mismatch_count, 32'd1);
    check("t7_done", 32'(done), 32'd0);
    cyc();
    check("t7_data_err_hold", 32'(data_err), 32'd1);
    check("t7_beat_count_hold", beat_count, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_aux_checker.md
Name: stream_aux_checker

Overview:
AXI-Stream test sink that sits directly downstream of the stream_aux counting source. It consumes one packet of incrementing words and applies a programmable tready backpressure pattern. Each accepted beat is checked against the expected sequence (first word 1, +1 per beat, tlast exactly on the word equal to total_num). Pass/fail, counts and a timeout flag are reported for bench and self-test use.

Parameters:
DATA_WIDTH, 32, width of tdata, total_num and the beat counters
TIMEOUT_CYCLES, 1024, RECV cycles without a handshake before timeout is flagged

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
tdata  input  DATA_WIDTH  stream data from upstream
tvalid  input  1  stream valid
tlast  input  1  stream last
tready  output  1  stream ready
enable  input  1  start/hold a check run; deassert to return to IDLE
total_num  input  DATA_WIDTH  expected packet length in beats, >=1, sampled on IDLE->RECV
ready_pattern  input  8  backpressure mask; bit[phase]=1 allows ready that cycle; 8'hFF = no backpressure
done  output  1  packet completed (tlast beat accepted), sticky until IDLE
pass  output  1  done && no error; valid only while done=1
data_err  output  1  sticky: an accepted beat had tdata != expected
last_err  output  1  sticky: tlast position wrong (early, or missing on final beat)
timeout  output  1  sticky: TIMEOUT_CYCLES consecutive RECV cycles without a handshake
beat_count  output  DATA_WIDTH  beats accepted in the current run
mismatch_count  output  DATA_WIDTH  accepted beats with data mismatch, saturating

Behaviour:
- Reset: state=IDLE, tready=0, done=0, pass=0, all error flags 0, beat_count=0, mismatch_count=0, expected=1, phase=0, timeout counter=0, captured length=0.
- Handshake: hs = tvalid && tready. Only hs beats are checked or counted. tready is registered and depends only on state and phase; it never depends on tvalid.
- States:
  - IDLE: tready=0. Moving to RECV when enable=1 takes one cycle. On entry: capture total_num, set expected=1, clear beat_count, mismatch_count, all error flags, done, pass and the timeout counter, set phase=0.
  - RECV: phase increments every cycle (3-bit wrap, 7->0). tready(next) = ready_pattern[phase_next].
    - On hs: beat_count+1; expected+1 (wraps modulo 2^DATA_WIDTH).
    - If tdata!=expected: data_err=1, mismatch_count+1 (saturating at all-ones).
    - If tlast=1 and expected!=captured length: last_err=1 and go to DONE (early end).
    - If tlast=0 and expected==captured length: last_err=1 and stay in RECV (overrun; keep checking until tlast).
    - If tlast=1 and expected==captured length: go to DONE.
  - DONE: tready=0. done=1. pass = !(data_err||last_err||timeout), registered in the same cycle that done rises.
- enable=0 in any state: next cycle go to IDLE and force tready=0. Flags, done and counts hold until the next IDLE->RECV entry.
- Timeout:
  - Counter increments in RECV on each cycle without hs and clears on hs.
  - When the counter reaches TIMEOUT_CYCLES-1, timeout=1 and the state goes to DONE.
  - The counter saturates and does not run in IDLE/DONE.
- Reset asserted mid-packet: immediate return to reset values; no partial results retained.
- Latency: the check result of beat N is visible on the flags the cycle after its hs. done rises the cycle after the tlast hs.
- ready_pattern=8'h00: tready is never asserted; timeout is the only exit.

Test Plan:
- total_num=4, ready_pattern=8'hFF, source beats 1,2,3,4 with tlast on 4 -> 4 hs in 4 consecutive cycles; done=1 and pass=1 one cycle after the tlast hs; beat_count=4; mismatch_count=0.
- total_num=16, ready_pattern=8'b1010_0101 -> tready follows the pattern cyclically; 16 beats accepted; pass=1; tvalid held high with unchanged data across non-ready cycles.
- total_num=5, beat 3 corrupted to 33 -> data_err=1, mismatch_count=1, pass=0 at done; beats 4 and 5 are still checked against 4 and 5 with no further errors.
- total_num=5, tlast sent on beat 3 -> last_err=1; DONE after 3 beats; beat_count=3, pass=0. Separate run with tlast missing on beat 5 and sent on beat 6 -> last_err=1, beat_count=6.
- TIMEOUT_CYCLES=16, tvalid held 0 in RECV -> timeout=1 after 16 cycles; done=1, pass=0. Separate run with ready_pattern=0 and tvalid=1 -> same result.
- Reset asserted after 2 of 8 beats, then enable re-raised -> all outputs return to reset values; the new run expects 1 again and passes with 8 clean beats. Separately, enable dropped mid-run -> IDLE, tready=0 next cycle, flags held.
